// File: rtl/apb_pkg.sv
// apb_pkg: shared state encodings and response codes for the APB master.
package apb_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'b00;
  localparam state_t SETUP  = 2'b01;
  localparam state_t ACCESS = 2'b11;
  typedef logic [1:0] rsp_code_t;
  localparam rsp_code_t RSP_OKAY    = 2'b00;
  localparam rsp_code_t RSP_SLVERR  = 2'b01;
  localparam rsp_code_t RSP_TIMEOUT = 2'b11;
endpackage

// File: rtl/apb_master_nslv_if.sv
// apb_master_nslv_if: request/response port and APB bus of the multi-slave master.
interface apb_master_nslv_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 4
);
  localparam int STRB_W = DATA_WIDTH / 8;
  logic                         i_req_valid;
  logic                         o_req_ready;
  logic                         i_req_write;
  logic [ADDR_WIDTH-1:0]        i_req_addr;
  logic [DATA_WIDTH-1:0]        i_req_wdata;
  logic [STRB_W-1:0]            i_req_strb;
  logic                         o_rsp_valid;
  logic [DATA_WIDTH-1:0]        o_rsp_rdata;
  logic                         o_rsp_error;
  logic                         o_rsp_timeout;
  logic [ADDR_WIDTH-1:0]        o_PADDR;
  logic [DATA_WIDTH-1:0]        o_PWDATA;
  logic [STRB_W-1:0]            o_PSTRB;
  logic                         o_PWRITE;
  logic [NUM_SLAVES-1:0]        o_PSEL;
  logic                         o_PENABLE;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_PRDATA;
  logic [NUM_SLAVES-1:0]        i_PREADY;
  logic [NUM_SLAVES-1:0]        i_PSLVERR;
  modport master (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_strb,
    input  i_PRDATA, i_PREADY, i_PSLVERR,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_error, o_rsp_timeout,
    output o_PADDR, o_PWDATA, o_PSTRB, o_PWRITE, o_PSEL, o_PENABLE
  );
  modport slave (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_strb,
    output i_PRDATA, i_PREADY, i_PSLVERR,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_error, o_rsp_timeout,
    input  o_PADDR, o_PWDATA, o_PSTRB, o_PWRITE, o_PSEL, o_PENABLE
  );
endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts stalled ACCESS cycles; expired flags the cycle that reaches TIMEOUT.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (en && TIMEOUT != 0) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  // The current stalled cycle is the TIMEOUT-th one when TIMEOUT-1 have already been counted.
  assign expired = (TIMEOUT != 0) && en && (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/apb_master_nslv.sv
// apb_master_nslv: valid/ready request port to APB with one-hot decoded PSEL,
// strobes, PSLVERR capture, wait-state timeout and back-to-back transfers.
module apb_master_nslv
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic i_PCLK,
  input  logic i_PRESET,
  apb_master_nslv_if.master bus
);
  localparam int SEL_W  = $clog2(NUM_SLAVES);
  localparam int STRB_W = DATA_WIDTH / 8;
  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic                    pwrite_q, pwrite_d;
  logic [NUM_SLAVES-1:0]   psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;
  logic                    rsp_timeout_q, rsp_timeout_d;
  logic                    ready_sel, err_sel, done, abort, expired, req_ready, accept;
  logic [DATA_WIDTH-1:0]   rdata_sel;
  rsp_code_t               code;
  assign ready_sel = bus.i_PREADY[sel_q];
  assign err_sel   = bus.i_PSLVERR[sel_q];
  assign rdata_sel = bus.i_PRDATA[sel_q*DATA_WIDTH +: DATA_WIDTH];
  assign done      = (state_q == ACCESS) && ready_sel;
  assign abort     = (state_q == ACCESS) && !ready_sel && expired;
  assign req_ready = (state_q == IDLE) || done;
  assign accept    = bus.i_req_valid && req_ready;
  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (i_PCLK),
    .rst     (i_PRESET),
    .clr     (state_q == SETUP),
    .en      ((state_q == ACCESS) && !ready_sel),
    .expired (expired)
  );
  // APB outputs are registered from the next state so SETUP/ACCESS appear the cycle they are entered.
  always_comb begin
    state_d       = accept ? SETUP
                  : (state_q == SETUP || (state_q == ACCESS && !done && !abort)) ? ACCESS : IDLE;
    sel_d         = accept ? bus.i_req_addr[ADDR_WIDTH-1 -: SEL_W] : sel_q;
    paddr_d       = accept ? bus.i_req_addr : paddr_q;
    pwrite_d      = accept ? bus.i_req_write : pwrite_q;
    pwdata_d      = accept ? (bus.i_req_write ? bus.i_req_wdata : '0) : pwdata_q;
    pstrb_d       = accept ? (bus.i_req_write ? bus.i_req_strb : '0) : pstrb_q;
    psel_d        = (state_d == IDLE) ? '0 : NUM_SLAVES'(1) << sel_d;
    penable_d     = state_d == ACCESS;
    code          = abort ? RSP_TIMEOUT : (done && err_sel) ? RSP_SLVERR : RSP_OKAY;
    rsp_valid_d   = done || abort;
    rsp_error_d   = code[0];
    rsp_timeout_d = code[1];
    rsp_rdata_d   = (done && !pwrite_q && !err_sel) ? rdata_sel : '0;
  end
  always_ff @(posedge i_PCLK) begin
    if (i_PRESET) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pwrite_q      <= 1'b0;
      psel_q        <= '0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pwrite_q      <= pwrite_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_error_q   <= rsp_error_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign bus.o_req_ready   = req_ready;
  assign bus.o_PADDR       = paddr_q;
  assign bus.o_PWDATA      = pwdata_q;
  assign bus.o_PSTRB       = pstrb_q;
  assign bus.o_PWRITE      = pwrite_q;
  assign bus.o_PSEL        = psel_q;
  assign bus.o_PENABLE     = penable_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_rdata   = rsp_rdata_q;
  assign bus.o_rsp_error   = rsp_error_q;
  assign bus.o_rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master_nslv.sv
// tb_apb_master_nslv: directed scenarios for the multi-slave APB master.
module tb_apb_master_nslv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  apb_master_nslv_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(4)) b ();
  apb_master_nslv #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .NUM_SLAVES(4), .TIMEOUT(16)) dut (
    .i_PCLK   (clk),
    .i_PRESET (rst),
    .bus      (b)
  );
  always #5 clk = ~clk;
  task automatic drive_req(input logic w, input logic [7:0] a, input logic [7:0] d, input logic s);
    b.i_req_valid = 1'b1;
    b.i_req_write = w;
    b.i_req_addr  = a;
    b.i_req_wdata = d;
    b.i_req_strb  = s;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (b.o_PSEL !== 4'b0000) begin failures++; $display("FAIL rst_psel got=%b exp=0000", b.o_PSEL); end
    checks++; if (b.o_PENABLE !== 1'b0) begin failures++; $display("FAIL rst_penable got=%b exp=0", b.o_PENABLE); end
    checks++; if (b.o_rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", b.o_rsp_valid); end
    checks++; if (b.o_PADDR !== 8'h00) begin failures++; $display("FAIL rst_paddr got=%h exp=00", b.o_PADDR); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (b.o_req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", b.o_req_ready); end
  endtask
  task automatic test_write();
    drive_req(1'b1, 8'hC5, 8'hA3, 1'b1);
    @(negedge clk);
    b.i_req_valid = 1'b0;
    checks++; if (b.o_PSEL !== 4'b1000) begin failures++; $display("FAIL wr_setup_psel got=%b exp=1000", b.o_PSEL); end
    checks++; if (b.o_PENABLE !== 1'b0) begin failures++; $display("FAIL wr_setup_penable got=%b exp=0", b.o_PENABLE); end
    checks++; if ({b.o_PADDR, b.o_PWDATA, b.o_PSTRB, b.o_PWRITE} !== {8'hC5, 8'hA3, 1'b1, 1'b1}) begin failures++;
      $display("FAIL wr_setup_bus got=%h/%h/%b/%b exp=c5/a3/1/1", b.o_PADDR, b.o_PWDATA, b.o_PSTRB, b.o_PWRITE); end
    @(negedge clk);
    checks++; if ({b.o_PSEL, b.o_PENABLE, b.o_rsp_valid} !== {4'b1000, 1'b1, 1'b0}) begin failures++;
      $display("FAIL wr_access got=%b/%b/%b exp=1000/1/0", b.o_PSEL, b.o_PENABLE, b.o_rsp_valid); end
    @(negedge clk);
    checks++; if ({b.o_rsp_valid, b.o_rsp_error, b.o_rsp_rdata} !== {1'b1, 1'b0, 8'h00}) begin failures++;
      $display("FAIL wr_rsp got=%b/%b/%h exp=1/0/00", b.o_rsp_valid, b.o_rsp_error, b.o_rsp_rdata); end
    checks++; if ({b.o_PSEL, b.o_PENABLE} !== 5'b0) begin failures++; $display("FAIL wr_idle got=%b/%b exp=0000/0", b.o_PSEL, b.o_PENABLE); end
    @(negedge clk);
    checks++; if (b.o_rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_rsp_pulse got=%b exp=0", b.o_rsp_valid); end
  endtask
  task automatic test_read_wait();
    b.i_PREADY = 4'b1101;
    drive_req(1'b0, 8'h42, 8'hFF, 1'b1);
    @(negedge clk);
    b.i_req_valid = 1'b0;
    checks++; if ({b.o_PSEL, b.o_PWDATA, b.o_PSTRB, b.o_PWRITE} !== {4'b0010, 8'h00, 1'b0, 1'b0}) begin failures++;
      $display("FAIL rd_setup got=%b/%h/%b/%b exp=0010/00/0/0", b.o_PSEL, b.o_PWDATA, b.o_PSTRB, b.o_PWRITE); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({b.o_PENABLE, b.o_rsp_valid, b.o_req_ready} !== 3'b100) begin failures++;
        $display("FAIL rd_wait%0d got=%b/%b/%b exp=1/0/0", i, b.o_PENABLE, b.o_rsp_valid, b.o_req_ready); end
    end
    @(negedge clk);
    b.i_PREADY = 4'b1111;
    #1;
    checks++; if ({b.o_PENABLE, b.o_req_ready, b.o_rsp_valid} !== 3'b110) begin failures++;
      $display("FAIL rd_done got=%b/%b/%b exp=1/1/0", b.o_PENABLE, b.o_req_ready, b.o_rsp_valid); end
    @(negedge clk);
    checks++; if ({b.o_rsp_valid, b.o_rsp_error, b.o_rsp_timeout, b.o_rsp_rdata} !== {3'b100, 8'h5A}) begin failures++;
      $display("FAIL rd_rsp got=%b/%b/%b/%h exp=1/0/0/5a", b.o_rsp_valid, b.o_rsp_error, b.o_rsp_timeout, b.o_rsp_rdata); end
  endtask
  task automatic test_back_to_back();
    drive_req(1'b1, 8'h10, 8'h33, 1'b1);
    @(negedge clk);
    checks++; if (b.o_PSEL !== 4'b0001) begin failures++; $display("FAIL b2b_psel0 got=%b exp=0001", b.o_PSEL); end
    drive_req(1'b0, 8'h80, 8'h00, 1'b0);
    @(negedge clk);
    checks++; if ({b.o_PSEL, b.o_PENABLE, b.o_req_ready} !== {4'b0001, 2'b11}) begin failures++;
      $display("FAIL b2b_acc0 got=%b/%b/%b exp=0001/1/1", b.o_PSEL, b.o_PENABLE, b.o_req_ready); end
    @(negedge clk);
    b.i_req_valid = 1'b0;
    checks++; if ({b.o_PSEL, b.o_PENABLE, b.o_rsp_valid, b.o_rsp_rdata} !== {4'b0100, 2'b01, 8'h00}) begin failures++;
      $display("FAIL b2b_seam got=%b/%b/%b/%h exp=0100/0/1/00", b.o_PSEL, b.o_PENABLE, b.o_rsp_valid, b.o_rsp_rdata); end
    @(negedge clk);
    checks++; if ({b.o_PSEL, b.o_PENABLE, b.o_rsp_valid} !== {4'b0100, 2'b10}) begin failures++;
      $display("FAIL b2b_acc1 got=%b/%b/%b exp=0100/1/0", b.o_PSEL, b.o_PENABLE, b.o_rsp_valid); end
    @(negedge clk);
    checks++; if ({b.o_rsp_valid, b.o_rsp_rdata, b.o_PSEL} !== {1'b1, 8'hC2, 4'b0000}) begin failures++;
      $display("FAIL b2b_rsp1 got=%b/%h/%b exp=1/c2/0000", b.o_rsp_valid, b.o_rsp_rdata, b.o_PSEL); end
  endtask
  task automatic test_slverr();
    b.i_PSLVERR = 4'b1000;
    drive_req(1'b0, 8'hC0, 8'h00, 1'b0);
    @(negedge clk);
    b.i_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({b.o_rsp_valid, b.o_rsp_error, b.o_rsp_timeout, b.o_rsp_rdata} !== {3'b110, 8'h00}) begin failures++;
      $display("FAIL slverr_rsp got=%b/%b/%b/%h exp=1/1/0/00", b.o_rsp_valid, b.o_rsp_error, b.o_rsp_timeout, b.o_rsp_rdata); end
    b.i_PSLVERR = 4'b0000;
  endtask
  task automatic test_timeout();
    int en_cnt;
    bit got;
    en_cnt = 0;
    got = 1'b0;
    b.i_PREADY = 4'b0000;
    drive_req(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    b.i_req_valid = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (b.o_rsp_valid) got = 1'b1;
      else if (b.o_PENABLE) begin
        en_cnt++;
        checks++; if (b.o_req_ready !== 1'b0) begin failures++; $display("FAIL to_ready_cycle%0d got=%b exp=0", en_cnt, b.o_req_ready); end
      end
    end
    checks++; if (!got) begin failures++; $display("FAIL to_no_rsp got=0 exp=1"); end
    checks++; if (en_cnt != 16) begin failures++; $display("FAIL to_penable_cycles got=%0d exp=16", en_cnt); end
    checks++; if ({b.o_PSEL, b.o_rsp_error, b.o_rsp_timeout, b.o_rsp_rdata} !== {4'b0000, 2'b11, 8'h00}) begin failures++;
      $display("FAIL to_rsp got=%b/%b/%b/%h exp=0000/1/1/00", b.o_PSEL, b.o_rsp_error, b.o_rsp_timeout, b.o_rsp_rdata); end
    b.i_PREADY = 4'b1111;
    drive_req(1'b1, 8'h40, 8'h77, 1'b1);
    #1;
    checks++; if (b.o_req_ready !== 1'b1) begin failures++; $display("FAIL to_next_ready got=%b exp=1", b.o_req_ready); end
    @(negedge clk);
    b.i_req_valid = 1'b0;
    checks++; if (b.o_PSEL !== 4'b0010) begin failures++; $display("FAIL to_next_psel got=%b exp=0010", b.o_PSEL); end
    repeat (2) @(negedge clk);
    checks++; if ({b.o_rsp_valid, b.o_rsp_error, b.o_rsp_timeout} !== 3'b100) begin failures++;
      $display("FAIL to_next_rsp got=%b/%b/%b exp=1/0/0", b.o_rsp_valid, b.o_rsp_error, b.o_rsp_timeout); end
  endtask
  task automatic test_reset_mid();
    b.i_PREADY = 4'b1101;
    drive_req(1'b1, 8'h42, 8'h99, 1'b1);
    @(negedge clk);
    b.i_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (b.o_PENABLE !== 1'b1) begin failures++; $display("FAIL rm_in_access got=%b exp=1", b.o_PENABLE); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({b.o_PSEL, b.o_PENABLE, b.o_PADDR, b.o_PWRITE, b.o_PWDATA, b.o_rsp_valid} !== 23'b0) begin failures++;
      $display("FAIL rm_cleared got=%b/%b/%h/%b/%h/%b exp=0000/0/00/0/00/0", b.o_PSEL, b.o_PENABLE, b.o_PADDR, b.o_PWRITE, b.o_PWDATA, b.o_rsp_valid); end
    rst = 1'b0;
    b.i_PREADY = 4'b1111;
    @(negedge clk);
    checks++; if ({b.o_rsp_valid, b.o_req_ready} !== 2'b01) begin failures++;
      $display("FAIL rm_after got=%b/%b exp=0/1", b.o_rsp_valid, b.o_req_ready); end
  endtask
  initial begin
    b.i_req_valid = 1'b0;
    b.i_req_write = 1'b0;
    b.i_req_addr  = '0;
    b.i_req_wdata = '0;
    b.i_req_strb  = '0;
    b.i_PRDATA    = {8'hD3, 8'hC2, 8'h5A, 8'hB0};
    b.i_PREADY    = 4'b1111;
    b.i_PSLVERR   = 4'b0000;
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
